// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: shares one RAM port between the instruction-fetch port (i_*)
// and the data port (d_*). Only one transaction is in flight at a time. When both
// ports request together, the grant alternates round-robin. A watchdog aborts an
// access that the RAM does not complete within TimeoutCycles BUSY cycles.
//
// Ports:
//   clk, rst                         clock; synchronous active-high reset
//   i_req, i_addr                    fetch request and address
//   i_ack, i_rdata                   fetch completion pulse; data held until next i_ack
//   d_req, d_addr, d_wdata, d_strobe data request (strobe 0 = read, else write)
//   d_ack, d_rdata                   data completion pulse; load data (0 for writes)
//   err                              high with the ack of an aborted access
//   mem_req, mem_addr, mem_wdata,    RAM request bundle, held for the whole access
//   mem_strobe
//   mem_ready, mem_rdata             RAM completion and read data
module memory_bus_arbiter #(
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned WordSize      = 4,
   parameter int unsigned TimeoutCycles = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_req,
   input  logic [AddrWidth-1:0] i_addr,
   output logic                 i_ack,
   output logic [DataWidth-1:0] i_rdata,
   input  logic                 d_req,
   input  logic [AddrWidth-1:0] d_addr,
   input  logic [DataWidth-1:0] d_wdata,
   input  logic [WordSize-1:0]  d_strobe,
   output logic                 d_ack,
   output logic [DataWidth-1:0] d_rdata,
   output logic                 err,
   output logic                 mem_req,
   output logic [AddrWidth-1:0] mem_addr,
   output logic [DataWidth-1:0] mem_wdata,
   output logic [WordSize-1:0]  mem_strobe,
   input  logic                 mem_ready,
   input  logic [DataWidth-1:0] mem_rdata
);

   localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // owner / last_grant / pick_d: 1 = data port, 0 = fetch port
   state_t                state, state_d;
   logic                  owner, owner_d;
   logic                  last_grant, last_grant_d;
   logic [CntWidth-1:0]   cnt, cnt_d;
   logic                  pick_d;
   logic                  timeout_c;
   logic [DataWidth-1:0]  resp_data_c;

   logic                  i_ack_d, d_ack_d, err_d, mem_req_d;
   logic [DataWidth-1:0]  i_rdata_d, d_rdata_d, mem_wdata_d;
   logic [AddrWidth-1:0]  mem_addr_d;
   logic [WordSize-1:0]   mem_strobe_d;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b0;
         cnt        <= '0;
         i_ack      <= 1'b0;
         i_rdata    <= '0;
         d_ack      <= 1'b0;
         d_rdata    <= '0;
         err        <= 1'b0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_strobe <= '0;
      end else begin
         state      <= state_d;
         owner      <= owner_d;
         last_grant <= last_grant_d;
         cnt        <= cnt_d;
         i_ack      <= i_ack_d;
         i_rdata    <= i_rdata_d;
         d_ack      <= d_ack_d;
         d_rdata    <= d_rdata_d;
         err        <= err_d;
         mem_req    <= mem_req_d;
         mem_addr   <= mem_addr_d;
         mem_wdata  <= mem_wdata_d;
         mem_strobe <= mem_strobe_d;
      end
   end

   // Watchdog fires on the last permitted BUSY cycle; mem_ready still wins there
   assign timeout_c = (cnt == CntWidth'(TimeoutCycles - 1));

   // Completed D writes and aborted accesses both return zero data
   assign resp_data_c = (mem_ready && !(owner && (mem_strobe != '0))) ? mem_rdata : '0;

   // Next-state and next-output logic
   always_comb begin
      state_d      = state;
      owner_d      = owner;
      last_grant_d = last_grant;
      cnt_d        = cnt;
      pick_d       = 1'b0;
      i_ack_d      = 1'b0;
      d_ack_d      = 1'b0;
      err_d        = 1'b0;
      i_rdata_d    = i_rdata;
      d_rdata_d    = d_rdata;
      mem_req_d    = mem_req;
      mem_addr_d   = mem_addr;
      mem_wdata_d  = mem_wdata;
      mem_strobe_d = mem_strobe;

      case (state)
         ST_IDLE: begin
            if (i_req || d_req) begin
               // D wins alone, or on a tie when I was granted last
               pick_d       = d_req && (!i_req || !last_grant);
               owner_d      = pick_d;
               last_grant_d = pick_d;
               cnt_d        = '0;
               mem_req_d    = 1'b1;
               mem_addr_d   = pick_d ? d_addr   : i_addr;
               mem_wdata_d  = pick_d ? d_wdata  : '0;
               mem_strobe_d = pick_d ? d_strobe : '0;
               state_d      = ST_BUSY;
            end
         end

         ST_BUSY: begin
            cnt_d = cnt + CntWidth'(1);
            if (mem_ready || timeout_c) begin
               mem_req_d    = 1'b0;
               mem_addr_d   = '0;
               mem_wdata_d  = '0;
               mem_strobe_d = '0;
               err_d        = !mem_ready;
               if (owner) begin
                  d_ack_d   = 1'b1;
                  d_rdata_d = resp_data_c;
               end else begin
                  i_ack_d   = 1'b1;
                  i_rdata_d = resp_data_c;
               end
               state_d = ST_RESP;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
module tb_memory_bus_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned WS = 4;
   localparam int unsigned TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req, d_req, i_ack, d_ack, err, mem_req, mem_ready;
   logic [AW-1:0] i_addr, d_addr, mem_addr;
   logic [DW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
   logic [WS-1:0] d_strobe, mem_strobe;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Reference model: which port was granted last (1 = D) and the data each port holds
   logic          lg;
   logic [DW-1:0] exp_irdata, exp_drdata;
   logic          last_owner;

   memory_bus_arbiter #(
      .DataWidth(DW), .AddrWidth(AW), .WordSize(WS), .TimeoutCycles(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_strobe(d_strobe),
      .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_strobe(mem_strobe), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_i_ack"},   32'(i_ack),   32'd0);
      check({tag, "_d_ack"},   32'(d_ack),   32'd0);
      check({tag, "_err"},     32'(err),     32'd0);
      check({tag, "_i_rdata"}, i_rdata,      32'd0);
      check({tag, "_d_rdata"}, d_rdata,      32'd0);
      check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
      check({tag, "_mem_addr"}, mem_addr,    32'd0);
      check({tag, "_mem_wdata"}, mem_wdata,  32'd0);
      check({tag, "_mem_strobe"}, 32'(mem_strobe), 32'd0);
   endtask

   // One whole transaction. Called in a cycle where the DUT is idle (or about to be)
   // and the pending requests are already on the pins. ready_at = BUSY cycle number
   // (1-based) that raises mem_ready; anything outside 1..TO means the RAM never answers.
   task automatic do_txn(input int wait_edges, input int ready_at,
                         input logic [DW-1:0] rd, input logic drop);
      logic own;
      logic done, werr;
      logic [DW-1:0] exp_data;
      int k;
      own = (i_req && d_req) ? !lg : d_req;
      k = 0;
      while (!mem_req && k < 8) begin
         step();
         k++;
      end
      check("grant_latency", 32'(k), 32'(wait_edges));
      if (!mem_req) return;
      lg = own;
      last_owner = own;
      check("grant_mem_addr", mem_addr, own ? d_addr : i_addr);
      check("grant_mem_wdata", mem_wdata, own ? d_wdata : 32'd0);
      check("grant_mem_strobe", 32'(mem_strobe), own ? 32'(d_strobe) : 32'd0);
      done = (ready_at >= 1) && (ready_at <= int'(TO));
      werr = !done;
      exp_data = (done && !(own && d_strobe != '0)) ? rd : '0;
      for (int j = 1; j <= int'(TO); j++) begin
         check("busy_mem_req", 32'(mem_req), 32'd1);
         check("busy_acks", {30'd0, i_ack, d_ack}, 32'd0);
         check("busy_nonowner_rdata", own ? i_rdata : d_rdata, own ? exp_irdata : exp_drdata);
         if (j == ready_at) begin
            mem_ready = 1'b1;
            mem_rdata = rd;
         end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
         end
         step();
         if (j == ready_at) break;
      end
      mem_ready = 1'b0;
      if (own) exp_drdata = exp_data; else exp_irdata = exp_data;
      check("resp_i_ack", 32'(i_ack), 32'(!own));
      check("resp_d_ack", 32'(d_ack), 32'(own));
      check("resp_err", 32'(err), 32'(werr));
      check("resp_i_rdata", i_rdata, exp_irdata);
      check("resp_d_rdata", d_rdata, exp_drdata);
      check("resp_mem_req", 32'(mem_req), 32'd0);
      check("resp_mem_bus", mem_addr | mem_wdata | 32'(mem_strobe), 32'd0);
      if (drop) begin
         if (own) d_req = 1'b0; else i_req = 1'b0;
      end
      step();
      check("ack_pulse", {29'd0, i_ack, d_ack, err}, 32'd0);
      check("idle_mem_req", 32'(mem_req), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      lg = 1'b0;
      exp_irdata = '0;
      exp_drdata = '0;
   endtask

   initial begin
      rst = 1'b1; i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0;
      d_wdata = '0; d_strobe = '0; mem_ready = 1'b0; mem_rdata = '0;
      do_reset();
      check_all_zero("reset");

      // Single fetch, immediate ready
      i_req = 1'b1; i_addr = 32'h100;
      do_txn(1, 1, 32'hDEADBEEF, 1'b1);

      // Fresh reset, both requesting: D write first, then I
      do_reset();
      i_req = 1'b1; i_addr = 32'h200;
      d_req = 1'b1; d_addr = 32'h300; d_wdata = 32'h1234; d_strobe = 4'b0011;
      do_txn(1, 1, 32'hAAAA5555, 1'b1);
      check("order_first_d", 32'(last_owner), 32'd1);
      do_txn(1, 2, 32'h0BADF00D, 1'b1);
      check("order_then_i", 32'(last_owner), 32'd0);

      // Both held for four transactions: D,I,D,I
      do_reset();
      i_req = 1'b1; d_req = 1'b1; d_strobe = 4'b0000;
      for (int t = 0; t < 4; t++) begin
         do_txn(1, 3, $urandom, 1'b0);
         check("rr_order", 32'(last_owner), 32'((t % 2) == 0));
      end
      i_req = 1'b0; d_req = 1'b0;
      step();

      // Data read that times out, then a stray mem_ready is ignored
      d_req = 1'b1; d_addr = 32'h44; d_strobe = 4'b0000;
      do_txn(1, 0, 32'h11111111, 1'b1);
      mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
      for (int j = 0; j < 3; j++) begin
         step();
         check("stray_ready_idle", {29'd0, mem_req, i_ack, d_ack}, 32'd0);
         check("stray_ready_drdata", d_rdata, 32'd0);
      end
      mem_ready = 1'b0;

      // Ready on the last allowed BUSY cycle completes normally
      d_req = 1'b1; d_addr = 32'h48;
      do_txn(1, int'(TO), 32'hCAFEF00D, 1'b1);

      // Reset during a fetch drops it; D then wins the next tie
      i_req = 1'b1; i_addr = 32'h500;
      step();
      check("rst_fetch_granted", 32'(mem_req), 32'd1);
      step();
      rst = 1'b1; i_req = 1'b0;
      step();
      check_all_zero("midrst");
      rst = 1'b0; lg = 1'b0; exp_irdata = '0; exp_drdata = '0;
      step();
      check_all_zero("midrst_after");
      i_req = 1'b1; i_addr = 32'h600;
      d_req = 1'b1; d_addr = 32'h700; d_strobe = 4'b0000;
      do_txn(1, 1, 32'h76543210, 1'b1);
      check("rst_then_d_first", 32'(last_owner), 32'd1);
      do_txn(1, 1, 32'h01234567, 1'b1);

      // Randomized traffic against the model
      for (int t = 0; t < 40; t++) begin
         if (!i_req && $urandom_range(0, 1) == 1) begin
            i_req = 1'b1; i_addr = $urandom;
         end
         if (!d_req && $urandom_range(0, 1) == 1) begin
            d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom;
            d_strobe = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
         end
         if (!i_req && !d_req) begin
            i_req = 1'b1; i_addr = $urandom;
         end
         do_txn(1, $urandom_range(1, 20), $urandom, 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
